// File: rtl/sar_search_if.sv
// sar_search_if: handshake and comparator bus for the SAR search controller
//   master: controller side (drives probe and status, reads start and flags)
//   slave : environment side (drives start and comparator flags)
interface sar_search_if #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = $clog2(WIDTH + 2)
);
  logic              start;
  logic [WIDTH-1:0]  probe;
  logic              cmp_lt;
  logic              cmp_gt;
  logic              cmp_eq;
  logic              busy;
  logic              done;
  logic              found;
  logic              err;
  logic [WIDTH-1:0]  result;
  logic [STEP_W-1:0] steps;
  modport master (
    input  start, cmp_lt, cmp_gt, cmp_eq,
    output probe, busy, done, found, err, result, steps
  );
  modport slave (
    output start, cmp_lt, cmp_gt, cmp_eq,
    input  probe, busy, done, found, err, result, steps
  );
endinterface

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: binary-search driver for a WIDTH-bit magnitude comparator
//   clk, rst_n  : clock and asynchronous active-low reset
//   bus.start   : begin a search (sampled in IDLE only)
//   bus.probe   : registered comparator a-operand
//   bus.cmp_*   : lt/gt/eq flags returned for the current probe
//   bus.busy/done/found/err/result/steps : status of the running/last search
module sar_search_ctrl #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = $clog2(WIDTH + 2)
) (
  input logic          clk,
  input logic          rst_n,
  sar_search_if.master bus
);
  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;
  state_t state;
  // one extra bit so lo can pass 2^WIDTH-1 and hi can fall below 0
  logic [WIDTH:0] lo, hi, nlo, nhi;
  logic [1:0] nflags;
  logic bad, under, stop;
  always_comb begin
    nflags = 2'(bus.cmp_lt) + 2'(bus.cmp_gt) + 2'(bus.cmp_eq);
    bad    = nflags != 2'd1;
    nlo    = bus.cmp_lt ? {1'b0, bus.probe} + (WIDTH+1)'(1) : lo;
    nhi    = bus.cmp_gt ? {1'b0, bus.probe} - (WIDTH+1)'(1) : hi;
    // hi wraps to all-ones on a gt at zero, so lo>hi would miss it
    under  = bus.cmp_gt && bus.probe == '0;
    stop   = bad || bus.cmp_eq || under || nlo > nhi;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lo         <= '0;
      hi         <= '0;
      bus.probe  <= '0;
      bus.result <= '0;
      bus.steps  <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.found  <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            lo        <= '0;
            hi        <= {1'b0, {WIDTH{1'b1}}};
            bus.probe <= {1'b0, {(WIDTH-1){1'b1}}};
            bus.steps <= '0;
            bus.found <= 1'b0;
            bus.err   <= 1'b0;
            bus.busy  <= 1'b1;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          bus.steps <= bus.steps + STEP_W'(1);
          if (stop) begin
            bus.result <= bus.probe;
            bus.found  <= !bad && bus.cmp_eq;
            bus.err    <= bad || !bus.cmp_eq;
            bus.done   <= 1'b1;
            state      <= DONE;
          end else begin
            lo        <= nlo;
            hi        <= nhi;
            bus.probe <= WIDTH'((nlo + nhi) >> 1);
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
